// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: opcodes, access sizes, write-back selects, FSM states.
package mem_access_unit_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WD_SEL_ALU  = 2'd0;
  localparam logic [1:0] WD_SEL_DRAM = 2'd1;
  localparam logic [1:0] WD_SEL_PC4  = 2'd2;
  localparam logic [1:0] WD_SEL_EXT  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data lane selection and sign/zero extension.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: single-outstanding req/gnt/rvalid data bus, stall, load align, MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned h/w accesses are suppressed and flagged on misalign_o.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEMinst,
  input  logic [31:0] MEMpc4,
  input  logic [31:0] MEMext,
  input  logic [31:0] MEMalu_c,
  input  logic [31:0] MEMrf_rD2,
  input  logic [1:0]  MEMwd_sel,
  input  logic        MEMrf_we,
  input  logic        MEMdram_we,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_o,
  output logic        bus_err,
  output logic [31:0] WBwd,
  output logic [4:0]  WBrd,
  output logic        WBrf_we
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  mau_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ld_data_q, ld_align;
  logic        abort_q, abort_d, err_q, err_d, mis_q, mis_d;
  logic [31:0] wbwd_q, wb_mux;
  logic [4:0]  wbrd_q;
  logic        wbwe_q;
  logic        is_load, is_store, memop, misaligned, timeout_hit, req_c, stall_c;
  logic [1:0]  size;
  logic [3:0]  be_enc;
  logic [31:0] wdata_enc;
  logic        unused_bits;

  assign is_load  = (MEMinst[6:0] == OPC_LOAD);
  assign is_store = MEMdram_we;
  assign memop    = is_load | is_store;
  assign size     = MEMinst[13:12];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = memop & (((size == 2'b01) & MEMalu_c[0]) |
                               (size[1] & (MEMalu_c[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Timeout compare is a no-op when BUS_TIMEOUT is 0.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (32'(cnt_q) == BUS_TIMEOUT - 1);

  always_comb begin
    case (size)
      2'b00: begin
        be_enc    = 4'b0001 << MEMalu_c[1:0];
        wdata_enc = {4{MEMrf_rD2[7:0]}};
      end
      2'b01: begin
        be_enc    = MEMalu_c[1] ? 4'b1100 : 4'b0011;
        wdata_enc = {2{MEMrf_rD2[15:0]}};
      end
      default: begin
        be_enc    = 4'b1111;
        wdata_enc = MEMrf_rD2;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_c = 1'b1;
          cnt_d   = '0;
          if (misaligned) begin
            state_d = DONE;
            abort_d = 1'b1;
            mis_d   = 1'b1;
          end else begin
            req_c   = 1'b1;
            state_d = dbus_gnt ? (is_store ? DONE : RESP) : REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (dbus_gnt) begin
          state_d = is_store ? DONE : RESP;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = DONE;
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (dbus_rvalid) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata_i  (dbus_rdata),
    .addr_lo_i(MEMalu_c[1:0]),
    .funct3_i (MEMinst[14:12]),
    .data_o   (ld_align)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_data_q <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      if (state_q == RESP && dbus_rvalid) ld_data_q <= ld_align;
    end
  end

  always_comb begin
    case (MEMwd_sel)
      WD_SEL_ALU:  wb_mux = MEMalu_c;
      WD_SEL_DRAM: wb_mux = ld_data_q;
      WD_SEL_PC4:  wb_mux = MEMpc4;
      default:     wb_mux = MEMext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbwd_q <= '0;
      wbrd_q <= '0;
      wbwe_q <= 1'b0;
    end else if (stall_c) begin
      wbwe_q <= 1'b0;
    end else begin
      wbwd_q <= wb_mux;
      wbrd_q <= MEMinst[11:7];
      wbwe_q <= MEMrf_we & ~abort_q;
    end
  end

  // Reset gates the combinational bus outputs so nothing is driven while rst_n is low.
  assign dbus_req   = req_c & rst_n;
  assign stall_o    = stall_c & rst_n;
  assign dbus_we    = dbus_req & is_store;
  assign dbus_addr  = dbus_req ? {MEMalu_c[31:2], 2'b00} : '0;
  assign dbus_be    = dbus_req ? be_enc : '0;
  assign dbus_wdata = (dbus_req & is_store) ? wdata_enc : '0;
  assign bus_err    = err_q;
  assign WBwd       = wbwd_q;
  assign WBrd       = wbrd_q;
  assign WBrf_we    = wbwe_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o  = mis_q;
  assign unused_bits = ^MEMinst[31:15];
`else
  assign unused_bits = ^{MEMinst[31:15], mis_q};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; build with MISALIGN_TRAP_EN to cover the trap path.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] MEMinst, MEMpc4, MEMext, MEMalu_c, MEMrf_rD2;
  logic [1:0]  MEMwd_sel;
  logic        MEMrf_we, MEMdram_we;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        stall_o, bus_err, WBrf_we;
  logic [31:0] WBwd;
  logic [4:0]  WBrd;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        we;
  } wb_t;
  wb_t sb_q[$];

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MEMinst    (MEMinst),
    .MEMpc4     (MEMpc4),
    .MEMext     (MEMext),
    .MEMalu_c   (MEMalu_c),
    .MEMrf_rD2  (MEMrf_rD2),
    .MEMwd_sel  (MEMwd_sel),
    .MEMrf_we   (MEMrf_we),
    .MEMdram_we (MEMdram_we),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_be    (dbus_be),
    .dbus_wdata (dbus_wdata),
    .dbus_gnt   (dbus_gnt),
    .dbus_rvalid(dbus_rvalid),
    .dbus_rdata (dbus_rdata),
    .stall_o    (stall_o),
    .bus_err    (bus_err),
    .WBwd       (WBwd),
    .WBrd       (WBrd),
    .WBrf_we    (WBrf_we)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o (misalign_o)
`endif
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {17'h0, f3, rd, opc};
  endfunction

  task automatic drive_nop();
    MEMinst = 32'h0000_0013; MEMalu_c = '0; MEMrf_rD2 = '0;
    MEMwd_sel = 2'd0; MEMrf_we = 1'b0; MEMdram_we = 1'b0;
  endtask

  // Drive one MEM-stage instruction, play the bus slave, check bus/stall/err, then WB via scoreboard.
  // gnt_dly: req cycles before gnt; rv_dly: RESP cycles before rvalid (-1 = never).
  task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic [1:0] wsel, input logic rfwe,
                        input logic dwe, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input int exp_stalls, input logic exp_err,
                        input logic exp_mis, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wd);
    wb_t e;
    int stalls = 0, req_cyc = 0, resp_cyc = 0, bus_seen = 0;
    bit granted = 0, done = 0;
    logic is_load;
    MEMinst = inst; MEMalu_c = alu; MEMrf_rD2 = rd2; MEMwd_sel = wsel;
    MEMrf_we = rfwe; MEMdram_we = dwe;
    is_load = (inst[6:0] == OP_LOAD);
    e.wd = exp_wd; e.rd = inst[11:7]; e.we = rfwe & ~exp_err & ~exp_mis;
    sb_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall_o) begin
        done = 1;
      end else begin
        stalls++;
        if (dbus_req) begin
          bus_seen++;
          checks++;
          if ({dbus_we, dbus_be, dbus_wdata, dbus_addr} !== {dwe, exp_be, exp_wdata, {alu[31:2], 2'b00}}) begin
            errors++;
            $display("FAIL %s bus: we=%b be=%b wdata=%h addr=%h, required we=%b be=%b wdata=%h addr=%h",
                     name, dbus_we, dbus_be, dbus_wdata, dbus_addr, dwe, exp_be, exp_wdata,
                     {alu[31:2], 2'b00});
          end
          if (!granted && req_cyc == gnt_dly) begin
            dbus_gnt = 1'b1;
            granted = 1;
          end
          req_cyc++;
        end else if (granted && is_load && rv_dly >= 0) begin
          if (resp_cyc == rv_dly) begin
            dbus_rvalid = 1'b1;
            dbus_rdata = rdata;
          end
          resp_cyc++;
        end
        @(negedge clk);
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata = 32'h5A5A_5A5A;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s stall_release: still stalled after 40 cycles, required release", name);
    end
    checks++;
    if (stalls !== exp_stalls) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_stalls);
    end
    checks++;
    if ({bus_err, dbus_req} !== {exp_err, 1'b0}) begin
      errors++;
      $display("FAIL %s done_cycle: bus_err=%b req=%b, required bus_err=%b req=0",
               name, bus_err, dbus_req, exp_err);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (misalign_o !== exp_mis) begin
      errors++;
      $display("FAIL %s misalign_o: got %b, required %b", name, misalign_o, exp_mis);
    end
`endif
    if (exp_mis) begin
      checks++;
      if (bus_seen != 0) begin
        errors++;
        $display("FAIL %s no_req: req seen %0d cycles, required 0", name, bus_seen);
      end
    end
    @(negedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (WBrf_we !== e.we || WBrd !== e.rd) begin
      errors++;
      $display("FAIL %s wb_ctl: rf_we=%b rd=%0d, required rf_we=%b rd=%0d", name, WBrf_we, WBrd, e.we, e.rd);
    end
    if (e.we) begin
      checks++;
      if (WBwd !== e.wd) begin
        errors++;
        $display("FAIL %s wb_data: got %h, required %h", name, WBwd, e.wd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    MEMpc4 = 32'h0000_0400; MEMext = 32'hFFFF_F800;
    drive_nop();
    repeat (2) @(negedge clk);
    checks++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_o, bus_err, WBwd, WBrd, WBrf_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h stall=%b err=%b wd=%h rd=%0d rfwe=%b, required all 0",
               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_o, bus_err, WBwd, WBrd, WBrf_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({stall_o, dbus_req, WBrf_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: stall=%b req=%b rfwe=%b, required 000", stall_o, dbus_req, WBrf_we);
    end
  endtask

  task automatic test_alu();
    run_op("add_x5", mk(3'b000, 5'd5, OP_ALU), 32'h1234, 32'h0, 2'd0, 1'b1, 1'b0,
           0, 0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0000_1234);
    run_op("jal_pc4", mk(3'b000, 5'd1, 7'b1101111), 32'h9999, 32'h0, 2'd2, 1'b1, 1'b0,
           0, 0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0000_0400);
    run_op("lui_ext", mk(3'b000, 5'd7, 7'b0110111), 32'h9999, 32'h0, 2'd3, 1'b1, 1'b0,
           0, 0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0, 32'hFFFF_F800);
  endtask

  task automatic test_store();
    run_op("sb", mk(3'b000, 5'd0, OP_STORE), 32'h0000_1003, 32'h1234_56AB, 2'd0, 1'b0, 1'b1,
           0, 0, 32'h0, 1, 1'b0, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0);
    run_op("sh", mk(3'b001, 5'd0, OP_STORE), 32'h0000_1002, 32'hCAFE_BEEF, 2'd0, 1'b0, 1'b1,
           1, 0, 32'h0, 2, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_op("sw", mk(3'b010, 5'd0, OP_STORE), 32'h0000_1004, 32'h1122_3344, 2'd0, 1'b0, 1'b1,
           0, 0, 32'h0, 1, 1'b0, 1'b0, 4'b1111, 32'h1122_3344, 32'h0);
  endtask

  task automatic test_load();
    run_op("lb", mk(3'b000, 5'd10, OP_LOAD), 32'h0000_2001, 32'h0, 2'd1, 1'b1, 1'b0,
           2, 0, 32'h0000_8000, 4, 1'b0, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FF80);
    run_op("lbu", mk(3'b100, 5'd11, OP_LOAD), 32'h0000_2001, 32'h0, 2'd1, 1'b1, 1'b0,
           2, 0, 32'h0000_8000, 4, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h0000_0080);
    run_op("lhu", mk(3'b101, 5'd12, OP_LOAD), 32'h0000_2002, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 0, 32'hBEEF_0000, 2, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0000_BEEF);
    run_op("lh", mk(3'b001, 5'd13, OP_LOAD), 32'h0000_2002, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 0, 32'hBEEF_0000, 2, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_BEEF);
    run_op("lw", mk(3'b010, 5'd14, OP_LOAD), 32'h0000_2000, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 1, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    run_op("ld_f3_110", mk(3'b110, 5'd15, OP_LOAD), 32'h0000_2000, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 0, 32'h89AB_CDEF, 2, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h89AB_CDEF);
  endtask

  task automatic test_timeout();
    run_op("to_resp", mk(3'b010, 5'd16, OP_LOAD), 32'h0000_2000, 32'h0, 2'd1, 1'b1, 1'b0,
           0, -1, 32'h0, 5, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0);
    run_op("to_req", mk(3'b010, 5'd17, OP_LOAD), 32'h0000_2000, 32'h0, 2'd1, 1'b1, 1'b0,
           99, 0, 32'h0, 5, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_sw", mk(3'b010, 5'd0, OP_STORE), 32'h0000_3000, 32'h0BAD_F00D, 2'd0, 1'b0, 1'b1,
           0, 0, 32'h0, 1, 1'b0, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0);
    run_op("b2b_lbu", mk(3'b100, 5'd20, OP_LOAD), 32'h0000_3003, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 0, 32'hF1E2_D3C4, 2, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h0000_00F1);
    run_op("b2b_add", mk(3'b000, 5'd21, OP_ALU), 32'h0000_5555, 32'h0, 2'd0, 1'b1, 1'b0,
           0, 0, 32'h0, 0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0000_5555);
  endtask

  task automatic test_reset_mid();
    MEMinst = mk(3'b010, 5'd9, OP_LOAD); MEMalu_c = 32'h0000_2000; MEMrf_rD2 = '0;
    MEMwd_sel = 2'd1; MEMrf_we = 1'b1; MEMdram_we = 1'b0;
    #1;
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    checks++;
    if ({stall_o, dbus_req} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_resp: stall=%b req=%b, required stall=1 req=0", stall_o, dbus_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_o, dbus_req, bus_err, WBrf_we, WBwd, WBrd} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: stall=%b req=%b err=%b rfwe=%b wd=%h rd=%0d, required all 0",
               stall_o, dbus_req, bus_err, WBrf_we, WBwd, WBrd);
    end
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hDEAD_0001;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({stall_o, dbus_req, bus_err, WBrf_we, WBwd, WBrd} !== '0) begin
      errors++;
      $display("FAIL rst_mid_late_rvalid: stall=%b req=%b err=%b rfwe=%b wd=%h rd=%0d, required all 0",
               stall_o, dbus_req, bus_err, WBrf_we, WBwd, WBrd);
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    run_op("lw_misalign", mk(3'b010, 5'd22, OP_LOAD), 32'h0000_3002, 32'h0, 2'd1, 1'b1, 1'b0,
           0, 0, 32'h0, 1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_timeout();
    test_back_to_back();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Decodes load/store from the MEM-stage instruction and drives a single-outstanding data bus with a req/gnt/rvalid handshake.
- Asserts a pipeline stall while an access is in flight. Aligns and sign/zero-extends load data.
- Registers the write-back value, rd and rf_we into the MEM/WB boundary.

Parameters:
- BUS_TIMEOUT, 255, cycles waited for gnt or rvalid before abort with bus_err; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- MEMinst  in  32  MEM-stage instruction; opcode/funct3/rd decoded here
- MEMpc4  in  32  pc+4, write-back source 2
- MEMext  in  32  immediate, write-back source 3
- MEMalu_c  in  32  ALU result / memory address, write-back source 0
- MEMrf_rD2  in  32  store data
- MEMwd_sel  in  2  write-back select: 0 alu, 1 dram, 2 pc4, 3 ext
- MEMrf_we  in  1  register write enable
- MEMdram_we  in  1  store request
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  load data valid
- dbus_rdata  in  32  load data
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- bus_err  out  1  one-cycle pulse on timeout
- WBwd  out  32  write-back data
- WBrd  out  5  destination register
- WBrf_we  out  1  write-back enable

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including dbus_* and stall_o.
- Decode:
  - load = opcode 7'b0000011.
  - store = MEMdram_we.
  - funct3 = MEMinst[14:12]: 000 b, 001 h, 010 w, 100 bu, 101 hu; other load funct3 treated as w.
- Non-memory instruction: no bus activity; stall_o=0. Next edge: WBwd=mux(MEMwd_sel), WBrd=MEMinst[11:7], WBrf_we=MEMrf_we.
- FSM IDLE:
  - Load or store: dbus_req=1 combinationally with stall_o=1.
  - gnt same cycle: store → DONE; load → RESP. No gnt → REQ.
- FSM REQ: hold req and all dbus_* stable until gnt. Then store → DONE, load → RESP.
- FSM RESP: req=0; wait rvalid. Capture extracted data, go to DONE.
- FSM DONE: stall_o=0 for one cycle so upstream advances. WB registers load at the DONE-cycle edge; FSM returns to IDLE.
- Minimum latency: store 1 stall cycle; load 2 stall cycles.
- stall_o=1 in IDLE-with-memop, REQ and RESP. Upstream holds MEM* inputs stable while stall_o=1.
- While stall_o=1, WBrf_we=0 (bubble into WB).
- Store encoding:
  - be = 0001<<a[1:0] (b), 0011<<{a[1],0} (h), 1111 (w).
  - wdata = byte replicated ×4, half ×2, or word.
  - dbus_addr = {a[31:2],2'b00}.
- Load extract: select byte/half by a[1:0]; sign-extend for b/h, zero-extend for bu/hu.
- Load write-back: WBwd = extracted data when MEMwd_sel=1; otherwise the mux source.
- rvalid outside RESP: ignored. gnt outside REQ/IDLE-req: ignored.
- Timeout:
  - Counter counts cycles in REQ or RESP, reset on state entry.
  - Reaching BUS_TIMEOUT: bus_err pulses 1 cycle, req drops, FSM → DONE with WBrf_we=0.
- Reset mid-access: immediate return to IDLE, req=0, stall_o=0. Any in-flight bus response is discarded.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - h with a[0]=1, or w with a[1:0]!=0, issues no bus request.
  - One stall cycle, then DONE with WBrf_we=0.
  - Extra port misalign_o (out, 1) pulses 1 cycle.
- Undefined: low address bits ignored for alignment; access proceeds (h uses a[1], w uses word). Port misalign_o absent.

Decomposition:
- Shared package (pipeline pkg):
  - OPC_LOAD constant.
  - FUNCT3 load/store size constants.
  - WD_SEL_ALU/DRAM/PC4/EXT encodings.
  - FSM state enum {IDLE, REQ, RESP, DONE}.
- Sub-module load_align: combinational rdata + a[1:0] + funct3 → 32-bit extended result. Reused by any future cache path.

Test Plan:
- add x5 (MEMwd_sel=0, alu_c=0x1234, rf_we=1, rd=5) → next edge WBwd=0x1234, WBrd=5, WBrf_we=1, stall_o never 1.
- sb a=0x1003, rD2=0xAB, gnt same cycle → dbus_be=1000, wdata=0xABABABAB, addr=0x1000, stall_o high exactly 1 cycle.
- lb a=0x2001, gnt delayed 2 cycles, rvalid 1 cycle later, rdata=0x0000_8000 → WBwd=0xFFFFFF80; same with lbu → 0x00000080. stall_o high 4 cycles.
- lhu a=0x2002, rdata=0xBEEF0000 → WBwd=0x0000BEEF; lh → 0xFFFFBEEF.
- BUS_TIMEOUT=4, load with rvalid never asserted → bus_err pulse after 4 RESP cycles, WBrf_we=0, FSM back to IDLE.
- rst_n low while in RESP, then a later rvalid → all outputs 0, stall_o=0, late rvalid ignored. With MISALIGN_TRAP_EN: lw a=0x3002 → misalign_o pulse, no dbus_req.
